// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   size_e  - access size encoding on req_size
//   err_e   - response error encoding on resp_err
//   state_e - FSM state encoding (also visible on lsu.dbg_state)
//   *_DEFAULT localparams - lane geometry for the default XLEN; modules
//   derive their own copies from their XLEN parameter the same way.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUS      = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned BYTES_DEFAULT = XLEN_DEFAULT / 8;
    localparam int unsigned OFF_W_DEFAULT = $clog2(BYTES_DEFAULT);

    // Number of bytes moved by an access of the given size.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

    // A dword access on a 32-bit unit has no legal alignment, so it is
    // reported as misaligned rather than being issued to memory.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input logic       dword_ok);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return !dword_ok || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the LSU.
//   size_i, unsigned_i, off_i - latched access size, zero-extend flag and
//                               byte offset within the XLEN word
//   wdata_i      - right-justified store data
//   rdata_i      - raw memory read word
//   load_data_o  - rdata shifted down by off, truncated and extended
//   store_data_o - size-truncated wdata replicated across every lane
//   store_mask_o - byte enables ((1<<bytes)-1)<<off
module lsu_align import lsu_pkg::*; #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BYTES = XLEN / 8,
    parameter int unsigned OFF_W = $clog2(BYTES)
) (
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [BYTES-1:0] store_mask_o
);

    logic [XLEN-1:0] shifted;
    logic [15:0]     ones;
    int unsigned     nbytes;

    always_comb begin
        shifted     = rdata_i >> {off_i, 3'b000};
        load_data_o = shifted;
        case (size_i)
            SZ_B: load_data_o = unsigned_i ? XLEN'(shifted[7:0])
                                           : XLEN'($signed(shifted[7:0]));
            SZ_H: load_data_o = unsigned_i ? XLEN'(shifted[15:0])
                                           : XLEN'($signed(shifted[15:0]));
            SZ_W: load_data_o = unsigned_i ? XLEN'(shifted[31:0])
                                           : XLEN'($signed(shifted[31:0]));
            default: load_data_o = shifted;
        endcase
    end

    always_comb begin
        // Clamp so an illegal dword on a 32-bit unit cannot index past wdata.
        nbytes = size_bytes(size_i);
        if (nbytes > BYTES) nbytes = BYTES;
        store_data_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            store_data_o[i*8 +: 8] = wdata_i[8*(i % nbytes) +: 8];
        end
        ones         = (16'd1 << nbytes) - 16'd1;
        store_mask_o = BYTES'(ones) << off_i;
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between a core-side request
// port and an XLEN-wide memory port.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   req_*                 - request port (valid/ready), latched in IDLE
//   resp_*                - response port (valid/ready), held until taken
//   mem_*                 - memory port; address is XLEN/8-aligned, store
//                           data replicated across lanes with a byte mask
//   dbg_state             - current FSM state (state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it stays raised, and its payload stays
// unchanged, until that edge. mem_rvalid is a one-shot strobe accepted only
// in WAIT.
module lsu import lsu_pkg::*; #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err,
    output logic [1:0]        dbg_state
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
    // Count value seen in the last REQ/WAIT cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;
    logic [BYTES-1:0]  store_mask;
    logic              timeout_hit;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .off_i        (addr_q[OFF_W-1:0]),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_rdata),
        .load_data_o  (load_data),
        .store_data_o (store_data),
        .store_mask_o (store_mask)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (is_misaligned(req_addr[2:0], req_size, XLEN == 64)) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completed handshake wins over a timeout in the same cycle.
                if (mem_ready) begin
                    if (we_q) begin
                        err_d   = mem_err ? ERR_BUS : ERR_OK;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = ERR_BUS;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    err_d   = mem_err ? ERR_BUS : ERR_OK;
                    rdata_d = mem_err ? '0 : load_data;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d   = ERR_BUS;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side outputs are forced to zero outside REQ so nothing stale
    // leaks onto the bus between transactions.
    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = (state_q == S_REQ);
    assign mem_we     = mem_valid & we_q;
    assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata  = mem_valid ? store_data : '0;
    assign mem_wmask  = mem_valid ? store_mask : '0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid ? err_q : 2'd0;
    assign dbg_state  = state_q;

endmodule
